// File: rtl/bcd_display_pkg.sv
// Shared constants for the BCD display scanner: segment patterns and slot phases.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package bcd_display_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0    = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b1000000;

  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } slot_phase_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to seven-segment decoder.
// Non-decimal nibbles render as a dash so a corrupted counter is visible.
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed seven-segment scanner: two-stage capture of asynchronous counter
// outputs, once-per-frame shadow load, guarded digit slots, leading-zero blanking.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int GUARD       = 50
) (
  input  logic                   Clk,
  input  logic                   Clr,
  input  logic [4*NDIGITS-1:0]   Bcd,
  input  logic [NDIGITS-1:0]     Dp,
  input  logic                   Blank_En,
  output logic [SEG_W-1:0]       Seg,
  output logic                   Dp_Out,
  output logic [NDIGITS-1:0]     An,
  output logic                   Frame
);

  localparam int CAP_W = 5 * NDIGITS;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [CAP_W-1:0]     s1_reg, s2_reg, shadow_reg, shadow_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [SEG_W-1:0]     seg_reg, seg_next;
  logic [NDIGITS-1:0]   an_reg, an_next;
  logic                 dp_out_reg, dp_out_next;
  logic                 frame_reg, frame_next;

  logic                 cnt_last, idx_last, frame_edge, stable;
  logic [4*NDIGITS-1:0] shadow_bcd;
  logic [NDIGITS-1:0]   shadow_dp;
  logic [3:0]           nib [NDIGITS];
  logic [NDIGITS-1:0]   nz, sup;
  logic [3:0]           nib_sel;
  logic                 dp_sel, sup_sel;
  logic [NDIGITS-1:0]   onehot;
  logic [SEG_W-1:0]     seg_dec;
  slot_phase_t          phase;

  assign shadow_bcd = shadow_reg[4*NDIGITS-1:0];
  assign shadow_dp  = shadow_reg[CAP_W-1:4*NDIGITS];

  assign cnt_last   = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
  assign idx_last   = (idx_reg == IDX_W'(NDIGITS - 1));
  assign frame_edge = cnt_last && idx_last;
  assign stable     = (s1_reg == s2_reg);

  // A digit is suppressed when it and every more significant nibble are zero.
  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
      assign nib[gi] = shadow_bcd[4*gi +: 4];
      assign nz[gi]  = |nib[gi];
      if (gi == 0) begin : g_lsd
        assign sup[gi] = 1'b0;
      end else begin : g_upper
        assign sup[gi] = Blank_En & ~(|nz[NDIGITS-1:gi]);
      end
    end
  endgenerate

  generate
    if (GUARD == 0) begin : g_no_guard
      assign phase = PH_DRIVE;
    end else begin : g_guard
      assign phase = (cnt_reg >= CNT_W'(GUARD)) ? PH_DRIVE : PH_GUARD;
    end
  endgenerate

  always_comb begin
    nib_sel = 4'd0;
    dp_sel  = 1'b0;
    sup_sel = 1'b0;
    onehot  = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        nib_sel   = nib[i];
        dp_sel    = shadow_dp[i];
        sup_sel   = sup[i];
        onehot[i] = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (nib_sel),
    .seg (seg_dec)
  );

  always_comb begin
    cnt_next    = cnt_last ? '0 : cnt_reg + CNT_W'(1);
    idx_next    = idx_reg;
    shadow_next = shadow_reg;
    frame_next  = frame_edge;
    seg_next    = '0;
    an_next     = '0;
    dp_out_next = 1'b0;
    if (cnt_last) begin
      idx_next = idx_last ? '0 : idx_reg + IDX_W'(1);
    end
    // An unsettled capture keeps the previous frame rather than showing a glitch.
    if (frame_edge && stable) begin
      shadow_next = s2_reg;
    end
    if (phase == PH_DRIVE) begin
      dp_out_next = dp_sel;
      if (!sup_sel) begin
        an_next  = onehot;
        seg_next = seg_dec;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      s1_reg     <= '0;
      s2_reg     <= '0;
      shadow_reg <= '0;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      seg_reg    <= '0;
      an_reg     <= '0;
      dp_out_reg <= 1'b0;
      frame_reg  <= 1'b0;
    end else begin
      s1_reg     <= {Dp, Bcd};
      s2_reg     <= s1_reg;
      shadow_reg <= shadow_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      seg_reg    <= seg_next;
      an_reg     <= an_next;
      dp_out_reg <= dp_out_next;
      frame_reg  <= frame_next;
    end
  end

  assign Seg    = seg_reg;
  assign An     = an_reg;
  assign Dp_Out = dp_out_reg;
  assign Frame  = frame_reg;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner with NDIGITS=4, REFRESH_DIV=8, GUARD=2.
// Expected frame contents are queued when stimulus is applied and popped per cycle.
module tb_bcd_display_scanner;

  logic        clk;
  logic        clr;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        blank_en;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic        frame;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  bcd_display_scanner #(
    .NDIGITS     (4),
    .REFRESH_DIV (8),
    .GUARD       (2)
  ) dut (
    .Clk      (clk),
    .Clr      (clr),
    .Bcd      (bcd_in),
    .Dp       (dp_in),
    .Blank_En (blank_en),
    .Seg      (seg),
    .Dp_Out   (dp_out),
    .An       (an),
    .Frame    (frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // Expected {Frame, Dp_Out, An, Seg} for digit slot i at prescaler count c.
  function automatic logic [31:0] ref_out(input int i, input int c, input logic [15:0] b,
                                          input logic [3:0] d, input logic blank,
                                          input logic fr);
    logic       drive, sup, lit;
    logic [3:0] a;
    logic [6:0] s;
    drive = (c >= 2);
    sup   = blank && (i > 0) && ((b >> (4 * i)) == 16'h0000);
    lit   = drive && !sup;
    a     = 4'b0000;
    s     = 7'b0000000;
    if (lit) begin
      a[i] = 1'b1;
      s    = ref_seg(b[4*i +: 4]);
    end
    return {19'b0, fr, drive ? d[i] : 1'b0, a, s};
  endfunction

  task automatic expect_frame(input logic [15:0] b, input logic [3:0] d, input logic blank);
    for (int k = 0; k < 32; k++) begin
      exp_q.push_back(ref_out(k / 8, k % 8, b, d, blank, k == 31));
    end
  endtask

  // Call at the negedge where Frame has just been seen high.
  task automatic run_frame(input string tag);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk(tag, {19'b0, frame, dp_out, an, seg}, exp_q.pop_front());
    end
    $display("frame %s bcd=%h dp=%b blank=%b checked", tag, bcd_in, dp_in, blank_en);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    while (!frame && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame_wait", 32'(frame), 32'd1);
  endtask

  task automatic sync_frame(input string tag, input logic [15:0] b, input logic [3:0] d,
                            input logic blank);
    int n;
    bcd_in   = b;
    dp_in    = d;
    blank_en = blank;
    @(negedge clk);
    wait_frame(n);
    expect_frame(b, d, blank);
    run_frame(tag);
  endtask

  initial begin
    int n;
    clr      = 1'b1;
    bcd_in   = 16'h0000;
    dp_in    = 4'b0000;
    blank_en = 1'b0;
    #1 clr = 1'b0;

    // Reset and release timing
    repeat (3) @(negedge clk);
    chk("reset_hold", {19'b0, frame, dp_out, an, seg}, 32'd0);
    clr = 1'b1;
    @(negedge clk);
    chk("rel_edge1", {19'b0, frame, dp_out, an, seg}, 32'd0);
    @(negedge clk);
    chk("rel_edge2", {19'b0, frame, dp_out, an, seg}, 32'd0);
    @(negedge clk);
    chk("rel_edge3", {19'b0, frame, dp_out, an, seg}, {19'b0, 1'b0, 1'b0, 4'b0001, 7'b0111111});
    @(posedge clk);
    #2 clr = 1'b0;
    #1 chk("async_clr", {19'b0, frame, dp_out, an, seg}, 32'd0);
    $display("reset sequence checked");

    // Steady scan, with first-frame latency from release
    bcd_in = 16'h1234;
    @(negedge clk);
    clr = 1'b1;
    wait_frame(n);
    chk("first_frame_edge", n, 32'd32);
    expect_frame(16'h1234, 4'b0000, 1'b0);
    run_frame("steady0");
    expect_frame(16'h1234, 4'b0000, 1'b0);
    run_frame("steady1");

    // Leading-zero blanking
    sync_frame("blank_0050", 16'h0050, 4'b0000, 1'b1);
    sync_frame("blank_0000", 16'h0000, 4'b0000, 1'b1);
    sync_frame("blank_0b00", 16'h0B00, 4'b0000, 1'b1);

    // Unstable input across a boundary keeps the old shadow
    sync_frame("load_0009", 16'h0009, 4'b0000, 1'b0);
    for (int k = 0; k < 32; k++) begin
      bcd_in = k[0] ? 16'h1111 : 16'h2222;
      @(negedge clk);
    end
    chk("unstable_pulse", 32'(frame), 32'd1);
    bcd_in = 16'h0009;
    expect_frame(16'h0009, 4'b0000, 1'b0);
    run_frame("unstable_hold");

    // Change one edge before the boundary: old frame kept, new loaded next time
    repeat (30) @(negedge clk);
    bcd_in = 16'h0567;
    repeat (2) @(negedge clk);
    chk("late_pulse", 32'(frame), 32'd1);
    expect_frame(16'h0009, 4'b0000, 1'b0);
    run_frame("late_old");
    expect_frame(16'h0567, 4'b0000, 1'b0);
    run_frame("late_new");

    // Decimal point, including on a suppressed digit
    sync_frame("dp_0100", 16'h1234, 4'b0100, 1'b0);
    sync_frame("dp_blank", 16'h0050, 4'b1000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Multiplexed seven-segment display driver that consumes the 4-bit BCD outputs of a chain of cascaded MOD-10 counters and scans them onto a common-anode-style digit bus. It sits directly downstream of the counter stage. The counter outputs are ripple-clocked and asynchronous to Clk, so this block samples them through a two-stage capture with a stability check. It loads a shadow copy once per frame and drives one digit at a time, with an anti-ghosting guard interval, optional leading-zero blanking and a frame-start pulse.

## Interface
- NDIGITS, 4: number of digits scanned; legal range ≥ 1.
- REFRESH_DIV, 1000: Clk cycles per digit slot; ≥ 2.
- GUARD, 50: blank cycles at the start of each slot; must satisfy 0 ≤ GUARD < REFRESH_DIV.
- Clk  input  1  single system clock; all state updates on its rising edge.
- Clr  input  1  asynchronous, active-low reset.
- Bcd  input  4*NDIGITS  counter outputs; nibble i is digit i, where digit 0 is least significant.
- Dp  input  NDIGITS  decimal-point request per digit.
- Blank_En  input  1  1 enables leading-zero suppression.
- Seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- Dp_Out  output  1  decimal point for the active digit, active-high, registered.
- An  output  NDIGITS  one-hot digit enable, active-high, registered; all zero when blank.
- Frame  output  1  one-cycle pulse marking a shadow-load / frame boundary.

## Operation
- **Capture:** on every edge, s1 <= {Dp,Bcd} and s2 <= s1. The input is stable when s1 == s2.
- **Prescaler:** cnt counts 0..REFRESH_DIV-1 and wraps to 0. At the wrap, idx <= (idx+1) mod NDIGITS.
- **Frame boundary:** the edge where cnt == REFRESH_DIV-1 and idx == NDIGITS-1.
  - Frame <= 1 on that edge and 0 otherwise.
  - If stable, shadow <= s2. If not stable, shadow holds its previous value; Frame still pulses.
- **Slot phases:**
  - GUARD phase (cnt < GUARD): An = 0, Seg = 0, Dp_Out = 0.
  - DRIVE phase (cnt ≥ GUARD): An = one-hot(idx), Seg = decode(shadow nibble idx), Dp_Out = shadow Dp[idx].
- **Leading-zero suppression:**
  - Applies when Blank_En = 1.
  - Digit i is suppressed if i > 0 and shadow nibbles i..NDIGITS-1 are all 0.
  - A suppressed digit gives An = 0 and Seg = 0 for its whole slot. Dp_Out still follows Dp[i]; An = 0 keeps it dark.
  - Digit 0 is never suppressed.
- **Decode:**
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Nibbles 10–15 decode to 1000000 ("-"), and this nibble counts as nonzero for suppression.
- **Reset (Clr = 0):** immediately and asynchronously, s1, s2, shadow, cnt and idx go to 0, and Seg, Dp_Out, An and Frame go to 0. Reset mid-slot or mid-frame aborts the scan; there is no partial-frame recovery.

## Timing
- **Output latency:** outputs are registered from pre-edge values of cnt, idx and shadow, so they lag the internal state by one cycle.
- **After Clr deasserts:**
  - Outputs first go active on edge GUARD+1 (digit 0, shadow = 0, so "0").
  - The first Frame pulse follows edge NDIGITS*REFRESH_DIV.
- **Periods:**
  - Digit slot: REFRESH_DIV cycles, of which the first GUARD are blank.
  - Frame period: NDIGITS*REFRESH_DIV cycles.
- **Display latency:** an input change shows on the display no earlier than the next frame boundary. It must be held steady for at least 2 edges before that boundary.
- **An constraint:** An changes only at phase boundaries and never has more than one bit set.

## Structure
- **Package `bcd_display_pkg`:**
  - Seven-segment constants SEG_0..SEG_9 and SEG_DASH.
  - Segment width 7.
  - Slot phase encoding: GUARD, DRIVE.
- **Sub-module `bcd_to_seg7`:** combinational 4-bit to 7-bit decoder. It is instantiated once and fed from a mux on idx.
- **Top level:** all other logic (capture, prescaler, idx, suppression mask, output registers) stays in the top module.

## Test plan
All scenarios use NDIGITS=4, REFRESH_DIV=8, GUARD=2.

1. **Async reset:** drive Clr low between edges, mid-DRIVE → Seg, An, Dp_Out and Frame read 0 before the next edge. After release, An = 0001 appears on edge 3 with Seg = 0111111.
2. **Steady scan:** Bcd = 16'h1234, Blank_En = 0, Dp = 0 → after the first Frame, An cycles 0001, 0010, 0100, 1000. Each is high for 6 of every 8 cycles. Seg is 1100110, 1001111, 1011011, 0000110 respectively. Frame has a 32-cycle period.
3. **Blanking:** Blank_En = 1.
   - Bcd = 16'h0050 → An[3] and An[2] are never asserted; digit 1 shows 1101101 and digit 0 shows 0111111.
   - Bcd = 16'h0000 → only An[0] is asserted.
   - Bcd = 16'h0B00 → digit 2 shows 1000000 and digit 3 is blank.
4. **Unstable input:** toggle Bcd between 16'h1111 and 16'h2222 every cycle across a frame boundary, starting from shadow = 16'h0009 → shadow stays 16'h0009 and Frame still pulses.
5. **Late change:** change Bcd one edge before the frame boundary → the old shadow is retained for that frame and the new value is loaded at the following boundary.
6. **Decimal point:** Dp = 4'b0100 → Dp_Out = 1 only while An = 0100 is in DRIVE.
